commit_unit: RTL and testbench

In-order retirement buffer that drives the register file's commit, PSR-commit and exception ports. Dispatch allocates one entry per instruction in program order; execution units complete entries out of order; the head retires at most one entry per cycle, writing its result, auto-increment writeback and status flags, or raising its exception and flushing everything younger.

---
 rtl/commit_unit_pkg.sv | 52 +++++
 rtl/commit_unit_if.sv | 61 ++++++
 rtl/commit_unit_entry_ram.sv | 70 +++++++
 rtl/commit_unit.sv | 161 ++++++++++++++++
 tb/tb_commit_unit.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types for the in-order commit unit: register tags, data words,
// condition flags, exception codes and the per-entry storage payloads.
package commit_unit_pkg;

    localparam int unsigned REG_TAG_W = 4;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned EXC_W     = 3;

    typedef logic [REG_TAG_W-1:0] RegTag;
    typedef logic [WORD_W-1:0]    Word;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } StatusFlags;

    typedef enum logic [EXC_W-1:0] {
        EXCEPT_NONE           = 3'd0,
        EXCEPT_ILLEGAL        = 3'd1,
        EXCEPT_PREFETCH_ABORT = 3'd2,
        EXCEPT_DATA_ABORT     = 3'd3,
        EXCEPT_SYSCALL        = 3'd4
    } Exception;

    // Link register used by the exception handler entry sequence.
    localparam RegTag LR = RegTag'(14);

    // Fields captured at dispatch.
    typedef struct packed {
        RegTag reg_tag;
        RegTag auto_inc_tag;
        logic  auto_inc;
        logic  sets_flags;
        Word   pc;
    } alloc_entry_t;

    // Fields captured when an execution unit reports back.
    typedef struct packed {
        Word        value;
        Word        auto_inc_value;
        StatusFlags flags;
        Exception   exc;
    } complete_entry_t;

    // A syscall returns past itself; faults re-execute the faulting instruction.
    function automatic Word link_address(input Exception exc, input Word pc);
        return (exc == EXCEPT_SYSCALL) ? pc + Word'(4) : pc;
    endfunction

endpackage

// File: rtl/commit_unit_if.sv
// Dispatch / execution / register-file signals of the commit unit.
interface commit_unit_if
    import commit_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) ();
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic             allocValid;
    logic             allocReady;
    RegTag            allocRegTag;
    RegTag            allocAutoIncRegTag;
    logic             allocAutoInc;
    logic             allocSetsFlags;
    Word              allocPc;
    logic [IDX_W-1:0] allocIndex;

    logic             completeValid;
    logic [IDX_W-1:0] completeIndex;
    Word              completeValue;
    Word              completeAutoIncValue;
    StatusFlags       completeFlags;
    Exception         completeException;

    RegTag            resultCommitRegTag;
    Word              resultCommitValue;
    logic             resultCommitEnable;
    RegTag            autoIncCommitRegTag;
    Word              autoIncCommitValue;
    logic             autoIncCommitEnable;
    StatusFlags       psrCommitValue;
    logic             psrCommitEnable;
    Exception         exception;
    Word              exceptionLinkAddress;
    logic             flush;

    modport slave (
        input  allocValid, allocRegTag, allocAutoIncRegTag, allocAutoInc,
               allocSetsFlags, allocPc,
        input  completeValid, completeIndex, completeValue,
               completeAutoIncValue, completeFlags, completeException,
        output allocReady, allocIndex,
        output resultCommitRegTag, resultCommitValue, resultCommitEnable,
               autoIncCommitRegTag, autoIncCommitValue, autoIncCommitEnable,
               psrCommitValue, psrCommitEnable,
               exception, exceptionLinkAddress, flush
    );

    modport master (
        output allocValid, allocRegTag, allocAutoIncRegTag, allocAutoInc,
               allocSetsFlags, allocPc,
        output completeValid, completeIndex, completeValue,
               completeAutoIncValue, completeFlags, completeException,
        input  allocReady, allocIndex,
        input  resultCommitRegTag, resultCommitValue, resultCommitEnable,
               autoIncCommitRegTag, autoIncCommitValue, autoIncCommitEnable,
               psrCommitValue, psrCommitEnable,
               exception, exceptionLinkAddress, flush
    );

endinterface

// File: rtl/commit_unit_entry_ram.sv
// Retirement-buffer storage: allocation and completion write ports,
// asynchronous head read, bulk invalidate on flush.
module commit_unit_entry_ram
    import commit_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clear_all,
    input  logic            i_alloc_we,
    input  logic [IDX_W-1:0] i_alloc_idx,
    input  alloc_entry_t    i_alloc_data,
    input  logic            i_comp_we,
    input  logic [IDX_W-1:0] i_comp_idx,
    input  complete_entry_t i_comp_data,
    input  logic            i_pop,
    input  logic [IDX_W-1:0] i_head_idx,
    output logic            o_head_valid_c,
    output logic            o_head_done_c,
    output alloc_entry_t    o_head_alloc_c,
    output complete_entry_t o_head_comp_c
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    alloc_entry_t     r_alloc_mem [DEPTH];
    complete_entry_t  r_comp_mem  [DEPTH];

    logic w_comp_ok;

    // Late or duplicate completions must not overwrite a finished result.
    assign w_comp_ok = i_comp_we & r_valid[i_comp_idx] & ~r_done[i_comp_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear_all) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (i_pop) begin
                r_valid[i_head_idx] <= 1'b0;
                r_done[i_head_idx]  <= 1'b0;
            end
            if (i_alloc_we) begin
                r_valid[i_alloc_idx] <= 1'b1;
                r_done[i_alloc_idx]  <= 1'b0;
            end
            if (w_comp_ok) begin
                r_done[i_comp_idx] <= 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only observed behind the valid/done bits.
    always_ff @(posedge i_clk) begin
        if (i_alloc_we) begin
            r_alloc_mem[i_alloc_idx] <= i_alloc_data;
        end
        if (w_comp_ok) begin
            r_comp_mem[i_comp_idx] <= i_comp_data;
        end
    end

    assign o_head_valid_c = r_valid[i_head_idx];
    assign o_head_done_c  = r_done[i_head_idx];
    assign o_head_alloc_c = r_alloc_mem[i_head_idx];
    assign o_head_comp_c  = r_comp_mem[i_head_idx];

endmodule

// File: rtl/commit_unit.sv
// In-order retirement buffer: allocates in program order, accepts
// out-of-order completions, retires or raises an exception at the head.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    commit_unit_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_alloc_ready;

    RegTag            r_result_tag;
    Word              r_result_value;
    logic             r_result_en;
    RegTag            r_ai_tag;
    Word              r_ai_value;
    logic             r_ai_en;
    StatusFlags       r_psr_value;
    logic             r_psr_en;
    Exception         r_exception;
    Word              r_link;
    logic             r_flush;

    logic             w_head_valid;
    logic             w_head_done;
    alloc_entry_t     w_head_alloc;
    complete_entry_t  w_head_comp;
    alloc_entry_t     w_alloc_data;
    complete_entry_t  w_comp_data;
    logic             w_retire;
    logic             w_retire_ok;
    logic             w_retire_exc;
    logic             w_alloc_fire;
    logic             w_comp_fire;
    logic [CNT_W-1:0] w_count_next;

    always_comb begin
        w_alloc_data.reg_tag        = bus.allocRegTag;
        w_alloc_data.auto_inc_tag   = bus.allocAutoIncRegTag;
        w_alloc_data.auto_inc       = bus.allocAutoInc;
        w_alloc_data.sets_flags     = bus.allocSetsFlags;
        w_alloc_data.pc             = bus.allocPc;
        w_comp_data.value           = bus.completeValue;
        w_comp_data.auto_inc_value  = bus.completeAutoIncValue;
        w_comp_data.flags           = bus.completeFlags;
        w_comp_data.exc             = bus.completeException;
    end

    // Head eligibility uses the registered done bit, so a same-cycle
    // completion of the head retires one cycle later.
    assign w_retire     = w_head_valid & w_head_done;
    assign w_retire_exc = w_retire & (w_head_comp.exc != EXCEPT_NONE);
    assign w_retire_ok  = w_retire & (w_head_comp.exc == EXCEPT_NONE);
    assign w_alloc_fire = bus.allocValid & r_alloc_ready;
    assign w_comp_fire  = bus.completeValid & ~r_flush;

    always_comb begin
        w_count_next = r_count;
        if (w_retire_exc) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_retire_ok);
        end
    end

    commit_unit_entry_ram #(
        .DEPTH (DEPTH)
    ) u_entry_ram (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_clear_all    (w_retire_exc),
        .i_alloc_we     (w_alloc_fire & ~w_retire_exc),
        .i_alloc_idx    (r_tail),
        .i_alloc_data   (w_alloc_data),
        .i_comp_we      (w_comp_fire),
        .i_comp_idx     (bus.completeIndex),
        .i_comp_data    (w_comp_data),
        .i_pop          (w_retire_ok),
        .i_head_idx     (r_head),
        .o_head_valid_c (w_head_valid),
        .o_head_done_c  (w_head_done),
        .o_head_alloc_c (w_head_alloc),
        .o_head_comp_c  (w_head_comp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_alloc_ready  <= 1'b1;
            r_result_tag   <= '0;
            r_result_value <= '0;
            r_result_en    <= 1'b0;
            r_ai_tag       <= '0;
            r_ai_value     <= '0;
            r_ai_en        <= 1'b0;
            r_psr_value    <= '0;
            r_psr_en       <= 1'b0;
            r_exception    <= EXCEPT_NONE;
            r_link         <= '0;
            r_flush        <= 1'b0;
        end else begin
            r_result_en   <= 1'b0;
            r_ai_en       <= 1'b0;
            r_psr_en      <= 1'b0;
            r_exception   <= EXCEPT_NONE;
            r_flush       <= 1'b0;
            r_count       <= w_count_next;
            // Ready reflects next-cycle occupancy and drops for the flush cycle.
            r_alloc_ready <= (w_count_next != FULL_COUNT) && !w_retire_exc;

            if (w_retire_ok) begin
                r_result_tag   <= w_head_alloc.reg_tag;
                r_result_value <= w_head_comp.value;
                r_result_en    <= (w_head_alloc.reg_tag != '0);
                r_ai_tag       <= w_head_alloc.auto_inc_tag;
                r_ai_value     <= w_head_comp.auto_inc_value;
                r_ai_en        <= w_head_alloc.auto_inc && (w_head_alloc.auto_inc_tag != '0);
                r_psr_value    <= w_head_comp.flags;
                r_psr_en       <= w_head_alloc.sets_flags;
                r_head         <= r_head + IDX_W'(1);
            end

            if (w_retire_exc) begin
                r_exception <= w_head_comp.exc;
                r_link      <= link_address(w_head_comp.exc, w_head_alloc.pc);
                r_flush     <= 1'b1;
                r_head      <= '0;
                r_tail      <= '0;
            end else if (w_alloc_fire) begin
                r_tail <= r_tail + IDX_W'(1);
            end
        end
    end

    assign bus.allocReady           = r_alloc_ready;
    assign bus.allocIndex           = r_tail;
    assign bus.resultCommitRegTag   = r_result_tag;
    assign bus.resultCommitValue    = r_result_value;
    assign bus.resultCommitEnable   = r_result_en;
    assign bus.autoIncCommitRegTag  = r_ai_tag;
    assign bus.autoIncCommitValue   = r_ai_value;
    assign bus.autoIncCommitEnable  = r_ai_en;
    assign bus.psrCommitValue       = r_psr_value;
    assign bus.psrCommitEnable      = r_psr_en;
    assign bus.exception            = r_exception;
    assign bus.exceptionLinkAddress = r_link;
    assign bus.flush                = r_flush;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_commit_unit;
    import commit_unit_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    commit_unit_if #(.DEPTH(DEPTH)) bus ();
    commit_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic av; RegTag tag; RegTag aitag; logic ai; logic sf; Word pc;
        logic cv; idx_t ci; Word cval; Word caiv; StatusFlags cf; Exception ce;
    } in_t;

    typedef struct {
        logic ready; idx_t index;
        logic res_en; RegTag res_tag; Word res_val;
        logic ai_en; RegTag ai_tag; Word ai_val;
        logic psr_en; StatusFlags psr_val;
        Exception exc; Word link; logic flush;
    } exp_t;

    typedef struct { in_t i; exp_t e; } vec_t;

    typedef struct {
        idx_t idx; RegTag tag; RegTag aitag; logic ai; logic sf; Word pc;
        logic done; Word val; Word aival; StatusFlags fl; Exception exc;
    } ment_t;

    vec_t tv [17];

    function automatic in_t in_idle();
        in_t x;
        x.av = 1'b0; x.tag = '0; x.aitag = '0; x.ai = 1'b0; x.sf = 1'b0; x.pc = '0;
        x.cv = 1'b0; x.ci = '0; x.cval = '0; x.caiv = '0; x.cf = '0; x.ce = EXCEPT_NONE;
        return x;
    endfunction

    function automatic in_t in_alloc(input int tag, input int aitag, input logic ai,
                                     input logic sf, input Word pc);
        in_t x = in_idle();
        x.av = 1'b1; x.tag = RegTag'(tag); x.aitag = RegTag'(aitag);
        x.ai = ai; x.sf = sf; x.pc = pc;
        return x;
    endfunction

    function automatic in_t in_comp(input int idx, input Word val, input Word aiv,
                                    input logic [3:0] fl, input Exception exc);
        in_t x = in_idle();
        x.cv = 1'b1; x.ci = idx_t'(idx); x.cval = val; x.caiv = aiv;
        x.cf = StatusFlags'(fl); x.ce = exc;
        return x;
    endfunction

    function automatic exp_t ex(input logic ready, input int index);
        exp_t e;
        e.ready = ready; e.index = idx_t'(index);
        e.res_en = 1'b0; e.res_tag = '0; e.res_val = '0;
        e.ai_en = 1'b0; e.ai_tag = '0; e.ai_val = '0;
        e.psr_en = 1'b0; e.psr_val = '0;
        e.exc = EXCEPT_NONE; e.link = '0; e.flush = 1'b0;
        return e;
    endfunction

    function automatic exp_t ex_res(input logic ready, input int index, input int tag, input Word val);
        exp_t e = ex(ready, index);
        e.res_en = 1'b1; e.res_tag = RegTag'(tag); e.res_val = val;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic drive(input in_t x);
        bus.allocValid           = x.av;
        bus.allocRegTag          = x.tag;
        bus.allocAutoIncRegTag   = x.aitag;
        bus.allocAutoInc         = x.ai;
        bus.allocSetsFlags       = x.sf;
        bus.allocPc              = x.pc;
        bus.completeValid        = x.cv;
        bus.completeIndex        = x.ci;
        bus.completeValue        = x.cval;
        bus.completeAutoIncValue = x.caiv;
        bus.completeFlags        = x.cf;
        bus.completeException    = x.ce;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_exp(input string n, input exp_t e);
        chk($sformatf("%s.ready", n), 32'(bus.allocReady), 32'(e.ready));
        chk($sformatf("%s.index", n), 32'(bus.allocIndex), 32'(e.index));
        chk($sformatf("%s.res_en", n), 32'(bus.resultCommitEnable), 32'(e.res_en));
        chk($sformatf("%s.ai_en", n), 32'(bus.autoIncCommitEnable), 32'(e.ai_en));
        chk($sformatf("%s.psr_en", n), 32'(bus.psrCommitEnable), 32'(e.psr_en));
        chk($sformatf("%s.exc", n), 32'(bus.exception), 32'(e.exc));
        chk($sformatf("%s.flush", n), 32'(bus.flush), 32'(e.flush));
        if (e.res_en) begin
            chk($sformatf("%s.res_tag", n), 32'(bus.resultCommitRegTag), 32'(e.res_tag));
            chk($sformatf("%s.res_val", n), bus.resultCommitValue, e.res_val);
        end
        if (e.ai_en) begin
            chk($sformatf("%s.ai_tag", n), 32'(bus.autoIncCommitRegTag), 32'(e.ai_tag));
            chk($sformatf("%s.ai_val", n), bus.autoIncCommitValue, e.ai_val);
        end
        if (e.psr_en)
            chk($sformatf("%s.psr_val", n), 32'(bus.psrCommitValue), 32'(e.psr_val));
        if (e.exc != EXCEPT_NONE)
            chk($sformatf("%s.link", n), bus.exceptionLinkAddress, e.link);
    endtask

    task automatic run(input string n, input in_t x, input exp_t e);
        drive(x);
        step();
        check_exp(n, e);
    endtask

    task automatic reset_dut();
        drive(in_idle());
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_zero_values(input string n);
        chk($sformatf("%s.res_tag0", n), 32'(bus.resultCommitRegTag), 32'h0);
        chk($sformatf("%s.res_val0", n), bus.resultCommitValue, 32'h0);
        chk($sformatf("%s.ai_tag0", n), 32'(bus.autoIncCommitRegTag), 32'h0);
        chk($sformatf("%s.ai_val0", n), bus.autoIncCommitValue, 32'h0);
        chk($sformatf("%s.psr0", n), 32'(bus.psrCommitValue), 32'h0);
        chk($sformatf("%s.link0", n), bus.exceptionLinkAddress, 32'h0);
    endtask

    task automatic random_run(input int cycles);
        ment_t q[$];
        idx_t  m_tail = '0;
        logic  m_flush = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            in_t   x = in_idle();
            exp_t  e;
            ment_t h;
            ment_t n;
            logic  ready_now = (q.size() != DEPTH) && !m_flush;
            logic  cand = (q.size() > 0) && q[0].done;
            logic  flush_next = 1'b0;
            int    r;
            if ($urandom_range(2) != 0) begin
                x.av = 1'b1;
                x.tag = RegTag'($urandom_range(15));
                x.aitag = RegTag'($urandom_range(15));
                x.ai = 1'($urandom_range(1));
                x.sf = 1'($urandom_range(1));
                x.pc = Word'($urandom) & 32'hFFFF_FFFC;
            end
            r = $urandom_range(99);
            if (r < 55 && q.size() > 0) begin
                x.cv = 1'b1;
                x.ci = q[$urandom_range(q.size() - 1)].idx;
            end else if (r < 65) begin
                x.cv = 1'b1;
                x.ci = idx_t'($urandom_range(DEPTH - 1));
            end
            if (x.cv) begin
                x.cval = Word'($urandom);
                x.caiv = Word'($urandom);
                x.cf = StatusFlags'(4'($urandom_range(15)));
                case ($urandom_range(47))
                    0: x.ce = EXCEPT_SYSCALL;
                    1: x.ce = EXCEPT_DATA_ABORT;
                    2: x.ce = EXCEPT_ILLEGAL;
                    default: x.ce = EXCEPT_NONE;
                endcase
            end

            if (cand) h = q[0];
            if (x.cv && !m_flush) begin
                foreach (q[j]) begin
                    if (q[j].idx == x.ci && !q[j].done) begin
                        q[j].done = 1'b1; q[j].val = x.cval; q[j].aival = x.caiv;
                        q[j].fl = x.cf; q[j].exc = x.ce;
                    end
                end
            end
            if (x.av && ready_now) begin
                n.idx = m_tail; n.tag = x.tag; n.aitag = x.aitag; n.ai = x.ai; n.sf = x.sf;
                n.pc = x.pc; n.done = 1'b0; n.val = '0; n.aival = '0; n.fl = '0; n.exc = EXCEPT_NONE;
                q.push_back(n);
                m_tail = idx_t'(m_tail + 1);
            end
            e = ex(1'b0, 0);
            if (cand) begin
                if (h.exc == EXCEPT_NONE) begin
                    e.res_en = (h.tag != 0); e.res_tag = h.tag; e.res_val = h.val;
                    e.ai_en = h.ai && (h.aitag != 0); e.ai_tag = h.aitag; e.ai_val = h.aival;
                    e.psr_en = h.sf; e.psr_val = h.fl;
                    void'(q.pop_front());
                end else begin
                    e.exc = h.exc;
                    e.link = (h.exc == EXCEPT_SYSCALL) ? h.pc + 32'd4 : h.pc;
                    flush_next = 1'b1;
                    q.delete();
                    m_tail = '0;
                end
            end
            m_flush = flush_next;
            e.flush = flush_next;
            e.ready = (q.size() != DEPTH) && !flush_next;
            e.index = m_tail;
            run("rand", x, e);
        end
    endtask

    initial begin
        // Directed table: single commit, auto-increment load, syscall flush.
        tv[0].i  = in_alloc(3, 0, 1'b0, 1'b0, 32'h100);        tv[0].e  = ex(1'b1, 1);
        tv[1].i  = in_comp(0, 32'hDEADBEEF, 32'h0, 4'h0, EXCEPT_NONE); tv[1].e = ex(1'b1, 1);
        tv[2].i  = in_idle();                                    tv[2].e  = ex_res(1'b1, 1, 3, 32'hDEADBEEF);
        tv[3].i  = in_idle();                                    tv[3].e  = ex(1'b1, 1);
        tv[4].i  = in_alloc(5, 6, 1'b1, 1'b1, 32'h104);          tv[4].e  = ex(1'b1, 2);
        tv[5].i  = in_comp(1, 32'h10, 32'h2004, 4'b1010, EXCEPT_NONE); tv[5].e = ex(1'b1, 2);
        tv[6].i  = in_idle();                                    tv[6].e  = ex_res(1'b1, 2, 5, 32'h10);
        tv[6].e.ai_en = 1'b1; tv[6].e.ai_tag = RegTag'(6); tv[6].e.ai_val = 32'h2004;
        tv[6].e.psr_en = 1'b1; tv[6].e.psr_val = StatusFlags'(4'b1010);
        tv[7].i  = in_idle();                                    tv[7].e  = ex(1'b1, 2);
        tv[8].i  = in_alloc(1, 0, 1'b0, 1'b0, 32'h200);          tv[8].e  = ex(1'b1, 3);
        tv[9].i  = in_alloc(2, 0, 1'b0, 1'b0, 32'h204);          tv[9].e  = ex(1'b1, 4);
        tv[10].i = in_alloc(4, 0, 1'b0, 1'b0, 32'h208);
        tv[10].i.cv = 1'b1; tv[10].i.ci = 3'd3; tv[10].i.cval = 32'h22; tv[10].e = ex(1'b1, 5);
        tv[11].i = in_comp(4, 32'h44, 32'h0, 4'h0, EXCEPT_NONE); tv[11].e = ex(1'b1, 5);
        tv[12].i = in_comp(2, 32'h0, 32'h0, 4'h0, EXCEPT_SYSCALL); tv[12].e = ex(1'b1, 5);
        tv[13].i = in_idle();                                    tv[13].e = ex(1'b0, 0);
        tv[13].e.exc = EXCEPT_SYSCALL; tv[13].e.link = 32'h204; tv[13].e.flush = 1'b1;
        tv[14].i = in_alloc(7, 0, 1'b0, 1'b0, 32'h300);
        tv[14].i.cv = 1'b1; tv[14].i.ci = 3'd0; tv[14].i.cval = 32'h77; tv[14].e = ex(1'b1, 0);
        tv[15].i = in_idle();                                    tv[15].e = ex(1'b1, 0);
        tv[16].i = in_idle();                                    tv[16].e = ex(1'b1, 0);

        reset_dut();
        check_exp("reset", ex(1'b1, 0));
        check_zero_values("reset");

        for (int k = 0; k < 17; k++) begin
            run($sformatf("vec%0d", k), tv[k].i, tv[k].e);
        end

        // Out-of-order completion still retires in program order.
        reset_dut();
        run("ooo.allocA", in_alloc(1, 0, 1'b0, 1'b0, 32'h10), ex(1'b1, 1));
        run("ooo.allocB", in_alloc(2, 0, 1'b0, 1'b0, 32'h14), ex(1'b1, 2));
        run("ooo.allocC", in_alloc(4, 0, 1'b0, 1'b0, 32'h18), ex(1'b1, 3));
        run("ooo.compC", in_comp(2, 32'h4444, 32'h0, 4'h0, EXCEPT_NONE), ex(1'b1, 3));
        run("ooo.compB", in_comp(1, 32'h2222, 32'h0, 4'h0, EXCEPT_NONE), ex(1'b1, 3));
        run("ooo.compA", in_comp(0, 32'h1111, 32'h0, 4'h0, EXCEPT_NONE), ex(1'b1, 3));
        run("ooo.retA", in_idle(), ex_res(1'b1, 3, 1, 32'h1111));
        run("ooo.retB", in_idle(), ex_res(1'b1, 3, 2, 32'h2222));
        run("ooo.retC", in_idle(), ex_res(1'b1, 3, 4, 32'h4444));
        run("ooo.idle", in_idle(), ex(1'b1, 3));

        // Fill, back-pressure, single free slot, wrap past the last index.
        reset_dut();
        for (int k = 0; k < 8; k++)
            run($sformatf("fill%0d", k), in_alloc(k + 1, 0, 1'b0, 1'b0, 32'h400 + 32'(4 * k)),
                ex(1'(k < 7), (k + 1) % 8));
        run("full.refused", in_alloc(9, 0, 1'b0, 1'b0, 32'h420), ex(1'b0, 0));
        run("full.comp0", in_comp(0, 32'h1000, 32'h0, 4'h0, EXCEPT_NONE), ex(1'b0, 0));
        run("full.ret0", in_idle(), ex_res(1'b1, 0, 1, 32'h1000));
        run("wrap.alloc", in_alloc(9, 0, 1'b0, 1'b0, 32'h420), ex(1'b0, 1));
        run("wrap.comp0", in_comp(0, 32'h9000, 32'h0, 4'h0, EXCEPT_NONE), ex(1'b0, 1));
        for (int k = 7; k >= 1; k--)
            run($sformatf("wrap.comp%0d", k), in_comp(k, 32'(32'h100 * k), 32'h0, 4'h0, EXCEPT_NONE),
                ex(1'b0, 1));
        for (int k = 1; k <= 7; k++)
            run($sformatf("wrap.ret%0d", k), in_idle(), ex_res(1'b1, 1, k + 1, 32'(32'h100 * k)));
        run("wrap.ret9", in_idle(), ex_res(1'b1, 1, 9, 32'h9000));
        run("wrap.idle", in_idle(), ex(1'b1, 1));

        // Reset with done entries stuck behind an unfinished head.
        reset_dut();
        for (int k = 0; k < 5; k++)
            run($sformatf("rst.alloc%0d", k),
                in_alloc((k == 0) ? int'(LR) : k, 0, 1'b0, 1'b0, 32'h600 + 32'(4 * k)), ex(1'b1, k + 1));
        for (int k = 1; k < 5; k++)
            run($sformatf("rst.comp%0d", k), in_comp(k, 32'(32'h50 + k), 32'h0, 4'h0, EXCEPT_NONE),
                ex(1'b1, 5));
        drive(in_idle());
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_exp("rst.after", ex(1'b1, 0));
        check_zero_values("rst.after");
        run("rst.stale", in_comp(0, 32'hBAD, 32'h0, 4'h0, EXCEPT_NONE), ex(1'b1, 0));
        run("rst.idle1", in_idle(), ex(1'b1, 0));
        run("rst.idle2", in_idle(), ex(1'b1, 0));
        run("rst.realloc", in_alloc(3, 0, 1'b0, 1'b0, 32'h700), ex(1'b1, 1));
        run("rst.idle3", in_idle(), ex(1'b1, 1));
        run("rst.idle4", in_idle(), ex(1'b1, 1));

        reset_dut();
        random_run(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
